// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the decode-stage control unit: opcode and function
// code values, field encodings for the datapath control signals, the packed
// control bundle carried from decoder to the ID/EX register, and a helper
// that derives the EX-stage forwardability flag from a bundle.
// Optional feature macro used by the users of this package:
//   CONTROL_HALT_OUT_EN - adds a registered halt output.
// ---------------------------------------------------------------------------
package control_pkg;

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BE    = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // R-type function codes
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;
  localparam logic [3:0] FN_SLL = 4'b1000;
  localparam logic [3:0] FN_SRL = 4'b1001;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Immediate field select
  localparam logic [1:0] SE_IMM4  = 2'b00;
  localparam logic [1:0] SE_IMM8  = 2'b01;
  localparam logic [1:0] SE_IMM12 = 2'b10;

  // Branch compare select
  localparam logic [1:0] CP_NONE = 2'b00;
  localparam logic [1:0] CP_LT   = 2'b01;
  localparam logic [1:0] CP_GT   = 2'b10;
  localparam logic [1:0] CP_EQ   = 2'b11;

  // Memory access size (shared by memRead and memWrite)
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Writeback source
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  // Control bundle produced by the decoder and held in the ID/EX register
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] se_src;
    logic [1:0] cp_ctrl;
    logic [1:0] mem_write;
    logic [1:0] mem_read;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       se_ctrl;
    logic       alu_src1;
    logic       alu_src4;
    logic       fw_src;
    logic       pc_src;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  // All-zero bundle is the NOP encoding
  localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

  // A result can be forwarded out of EX only when it is written back and
  // comes from the ALU rather than from memory.
  function automatic logic fw_src_of(input ctrl_t c);
    return c.reg_write & (c.mem_to_reg == WB_ALU);
  endfunction

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational instruction decoder. Maps the opcode / function code
// of the instruction in decode onto the datapath control bundle.
// Ports:
//   op_code_i  [3:0]  instruction opcode
//   fun_code_i [3:0]  function field (used only for R-type)
//   ctrl_o            decoded control bundle (control_pkg::ctrl_t)
//   halt_o            opcode is HALT (only with CONTROL_HALT_OUT_EN)
// Optional feature macro: CONTROL_HALT_OUT_EN.
// ---------------------------------------------------------------------------
module control_decode
  import control_pkg::*;
(
  input  logic [3:0] op_code_i,
  input  logic [3:0] fun_code_i,
  output ctrl_t      ctrl_o
`ifdef CONTROL_HALT_OUT_EN
  ,
  output logic       halt_o
`endif
);

  ctrl_t ctrl_s;

  // Opcode / function code decode; anything unrecognised stays at NOP
  always_comb begin
    ctrl_s = CTRL_NOP;
    case (op_code_i)
      OP_RTYPE: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src4  = 1'b0;
        case (fun_code_i)
          FN_ADD:  ctrl_s.alu_op = ALU_ADD;
          FN_SUB:  ctrl_s.alu_op = ALU_SUB;
          FN_MUL:  ctrl_s.alu_op = ALU_MUL;
          FN_DIV:  ctrl_s.alu_op = ALU_DIV;
          FN_SLL:  ctrl_s.alu_op = ALU_SLL;
          FN_SRL:  ctrl_s.alu_op = ALU_SRL;
          // Unknown function: whole bundle collapses back to NOP
          default: ctrl_s = CTRL_NOP;
        endcase
      end
      OP_ANDI, OP_ORI: begin
        // Logical immediates zero-extend imm8
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op    = (op_code_i == OP_ANDI) ? ALU_AND : ALU_OR;
        ctrl_s.alu_src4  = 1'b1;
        ctrl_s.se_src    = SE_IMM8;
        ctrl_s.se_ctrl   = 1'b0;
      end
      OP_LBU, OP_LW: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_read   = (op_code_i == OP_LBU) ? MEM_BYTE : MEM_WORD;
        ctrl_s.mem_to_reg = WB_MEM;
        ctrl_s.alu_op     = ALU_ADD;
        ctrl_s.alu_src4   = 1'b1;
        ctrl_s.se_src     = SE_IMM4;
        ctrl_s.se_ctrl    = 1'b1;
      end
      OP_SB, OP_SW: begin
        ctrl_s.mem_write = (op_code_i == OP_SB) ? MEM_BYTE : MEM_WORD;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.alu_src4  = 1'b1;
        ctrl_s.se_src    = SE_IMM4;
        ctrl_s.se_ctrl   = 1'b1;
      end
      OP_BLT, OP_BGT, OP_BE: begin
        // Target = PC + sext(imm8), computed on the ALU
        case (op_code_i)
          OP_BLT:  ctrl_s.cp_ctrl = CP_LT;
          OP_BGT:  ctrl_s.cp_ctrl = CP_GT;
          OP_BE:   ctrl_s.cp_ctrl = CP_EQ;
          default: ctrl_s.cp_ctrl = CP_NONE;
        endcase
        ctrl_s.alu_op   = ALU_ADD;
        ctrl_s.alu_src1 = 1'b1;
        ctrl_s.alu_src4 = 1'b1;
        ctrl_s.se_src   = SE_IMM8;
        ctrl_s.se_ctrl  = 1'b1;
      end
      OP_JMP: begin
        ctrl_s.pc_src  = 1'b1;
        ctrl_s.se_src  = SE_IMM12;
        ctrl_s.se_ctrl = 1'b1;
      end
      OP_HALT: ctrl_s = CTRL_NOP;
      default: ctrl_s = CTRL_NOP;
    endcase
    ctrl_s.fw_src = fw_src_of(ctrl_s);
  end

  assign ctrl_o = ctrl_s;

`ifdef CONTROL_HALT_OUT_EN
  assign halt_o = (op_code_i == OP_HALT);
`endif

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Main decoder between the IF/ID and ID/EX registers. Decodes opCode/funCode
// through control_decode and registers the resulting control signals, plus
// copies of opCode/funCode for the hazard and forwarding logic. One cycle of
// latency, no handshake; synchronous active-high reset clears every output
// to the all-zero NOP encoding and discards the decode in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opCode, funCode [3:0]    instruction fields in decode
//   fw_opCode, fw_funCode    registered copies of the inputs
//   aluOp[2:0] seSrc[1:0] cpCtrl[1:0] memWrite[1:0] memRead[1:0]
//   memToReg[1:0] regWrite seCtrl aluSrc1 aluSrc4 fwSrc pcSrc
//                            registered datapath control
//   halt                     registered HALT flag (CONTROL_HALT_OUT_EN only)
// Optional feature macro: CONTROL_HALT_OUT_EN.
// ---------------------------------------------------------------------------
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opCode,
  input  logic [3:0] funCode,
  output logic [3:0] fw_opCode,
  output logic [3:0] fw_funCode,
  output logic [2:0] aluOp,
  output logic [1:0] seSrc,
  output logic [1:0] cpCtrl,
  output logic [1:0] memWrite,
  output logic [1:0] memRead,
  output logic [1:0] memToReg,
  output logic       regWrite,
  output logic       seCtrl,
  output logic       aluSrc1,
  output logic       aluSrc4,
  output logic       fwSrc,
  output logic       pcSrc
`ifdef CONTROL_HALT_OUT_EN
  ,
  output logic       halt
`endif
);

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic [3:0] fw_op_d;
  logic [3:0] fw_op_q;
  logic [3:0] fw_fun_d;
  logic [3:0] fw_fun_q;

`ifdef CONTROL_HALT_OUT_EN
  logic halt_d;
  logic halt_q;
`endif

  control_decode u_decode (
    .op_code_i  (opCode),
    .fun_code_i (funCode),
    .ctrl_o     (ctrl_d)
`ifdef CONTROL_HALT_OUT_EN
    ,
    .halt_o     (halt_d)
`endif
  );

  // Raw instruction fields pass straight through to the register stage
  always_comb begin
    fw_op_d  = opCode;
    fw_fun_d = funCode;
  end

  // ID/EX control register; reset takes priority over the new decode
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= CTRL_NOP;
      fw_op_q  <= 4'b0000;
      fw_fun_q <= 4'b0000;
    end else begin
      ctrl_q   <= ctrl_d;
      fw_op_q  <= fw_op_d;
      fw_fun_q <= fw_fun_d;
    end
  end

`ifdef CONTROL_HALT_OUT_EN
  // Registered HALT flag, high for the cycle after HALT is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign halt = halt_q;
`endif

  assign fw_opCode  = fw_op_q;
  assign fw_funCode = fw_fun_q;
  assign aluOp      = ctrl_q.alu_op;
  assign seSrc      = ctrl_q.se_src;
  assign cpCtrl     = ctrl_q.cp_ctrl;
  assign memWrite   = ctrl_q.mem_write;
  assign memRead    = ctrl_q.mem_read;
  assign memToReg   = ctrl_q.mem_to_reg;
  assign regWrite   = ctrl_q.reg_write;
  assign seCtrl     = ctrl_q.se_ctrl;
  assign aluSrc1    = ctrl_q.alu_src1;
  assign aluSrc4    = ctrl_q.alu_src4;
  assign fwSrc      = ctrl_q.fw_src;
  assign pcSrc      = ctrl_q.pc_src;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench for control_unit: each directed vector pushes its
// hand-computed expected output word when driven; a monitor pops and
// compares one cycle later, after the registering edge.
// Expected word layout (28 bits, MSB first):
//   fw_opCode[4] fw_funCode[4] aluOp[3] seSrc[2] cpCtrl[2] memWrite[2]
//   memRead[2] memToReg[2] regWrite seCtrl aluSrc1 aluSrc4 fwSrc pcSrc halt
// ---------------------------------------------------------------------------
module tb_control_unit;

`ifdef CONTROL_HALT_OUT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opCode = 4'b0010;
  logic [3:0] funCode = 4'b0000;
  logic [3:0] fw_opCode, fw_funCode;
  logic [2:0] aluOp;
  logic [1:0] seSrc, cpCtrl, memWrite, memRead, memToReg;
  logic       regWrite, seCtrl, aluSrc1, aluSrc4, fwSrc, pcSrc;
  logic       halt_s;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opCode     (opCode),
    .funCode    (funCode),
    .fw_opCode  (fw_opCode),
    .fw_funCode (fw_funCode),
    .aluOp      (aluOp),
    .seSrc      (seSrc),
    .cpCtrl     (cpCtrl),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .seCtrl     (seCtrl),
    .aluSrc1    (aluSrc1),
    .aluSrc4    (aluSrc4),
    .fwSrc      (fwSrc),
    .pcSrc      (pcSrc)
`ifdef CONTROL_HALT_OUT_EN
    ,
    .halt       (halt_s)
`endif
  );

`ifndef CONTROL_HALT_OUT_EN
  assign halt_s = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [27:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       pass_cnt  = 0;
  int       total_cnt = 0;

  // Pack individual expected fields into the compare word
  function automatic logic [27:0] mk(
    input logic [3:0] fop, input logic [3:0] ffn, input logic [2:0] alu,
    input logic [1:0] se, input logic [1:0] cp, input logic [1:0] mw,
    input logic [1:0] mr, input logic [1:0] m2r, input logic rw,
    input logic sec, input logic a1, input logic a4, input logic fws,
    input logic pc, input logic h);
    return {fop, ffn, alu, se, cp, mw, mr, m2r, rw, sec, a1, a4, fws, pc, h};
  endfunction

  // Drive one vector on the falling edge and queue its expected result
  task automatic drive(input string nm, input logic r, input logic [3:0] op,
                       input logic [3:0] fn, input logic [27:0] e);
    sb_item_t it;
    @(negedge clk);
    rst     = r;
    opCode  = op;
    funCode = fn;
    it.name = nm;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  // Monitor: compare outputs just after each rising edge
  initial begin
    logic [27:0] act;
    sb_item_t    it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {fw_opCode, fw_funCode, aluOp, seSrc, cpCtrl, memWrite, memRead,
               memToReg, regWrite, seCtrl, aluSrc1, aluSrc4, fwSrc, pcSrc, halt_s};
        total_cnt++;
        if (act === it.exp) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: got %b, expected %b", it.name, act, it.exp);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int wait_cyc;
    //           name        rst   op       fun      fop      ffn      alu     se     cp     mw     mr     m2r    rw    sec   a1    a4    fws   pc    halt
    drive("reset1",   1'b1, 4'b0010, 4'b0000, mk(4'b0000, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("reset2",   1'b1, 4'b0010, 4'b0000, mk(4'b0000, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("r_mul",    1'b0, 4'b0000, 4'b0100, mk(4'b0000, 4'b0100, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("r_sub",    1'b0, 4'b0000, 4'b0001, mk(4'b0000, 4'b0001, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("r_srl",    1'b0, 4'b0000, 4'b1001, mk(4'b0000, 4'b1001, 3'b111, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("r_sll",    1'b0, 4'b0000, 4'b1000, mk(4'b0000, 4'b1000, 3'b110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("r_div",    1'b0, 4'b0000, 4'b0101, mk(4'b0000, 4'b0101, 3'b101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("andi",     1'b0, 4'b0001, 4'b0011, mk(4'b0001, 4'b0011, 3'b010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    drive("ori",      1'b0, 4'b0010, 4'b0000, mk(4'b0010, 4'b0000, 3'b011, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    drive("lbu",      1'b0, 4'b1010, 4'b0000, mk(4'b1010, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("sb",       1'b0, 4'b1011, 4'b0000, mk(4'b1011, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("lw",       1'b0, 4'b1100, 4'b0000, mk(4'b1100, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("sw",       1'b0, 4'b1101, 4'b0000, mk(4'b1101, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("blt",      1'b0, 4'b0101, 4'b0000, mk(4'b0101, 4'b0000, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("bgt",      1'b0, 4'b0100, 4'b0000, mk(4'b0100, 4'b0000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("be",       1'b0, 4'b0110, 4'b0000, mk(4'b0110, 4'b0000, 3'b000, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    drive("jmp",      1'b0, 4'b0111, 4'b0000, mk(4'b0111, 4'b0000, 3'b000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    drive("halt",     1'b0, 4'b1111, 4'b0000, mk(4'b1111, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HALT_EN));
    drive("r_badfn",  1'b0, 4'b0000, 4'b1111, mk(4'b0000, 4'b1111, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("undef_e",  1'b0, 4'b1110, 4'b0101, mk(4'b1110, 4'b0101, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("undef_3",  1'b0, 4'b0011, 4'b0010, mk(4'b0011, 4'b0010, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("halt2",    1'b0, 4'b1111, 4'b1010, mk(4'b1111, 4'b1010, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HALT_EN));
    drive("rst_lw",   1'b1, 4'b1100, 4'b0000, mk(4'b0000, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive("r_add",    1'b0, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive("undef_8",  1'b0, 4'b1000, 4'b0001, mk(4'b1000, 4'b0001, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Let the monitor drain the scoreboard, with a bounded wait
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
